// File: rtl/io_input_conditioner.sv
// -----------------------------------------------------------------------------
// io_input_conditioner
//
// Front end for the three IO input channels of the 16-bit CPU board. Each
// channel synchronises a raw asynchronous pin through two flops, debounces
// the synchronised level, and presents a clean level plus a pending-event
// flag. The flag is held until the consumer acknowledges it. A sticky overrun
// bit records an event that arrived while the previous one was still pending.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronised cycles a new value must persist
//                    before it is accepted (1 .. 2^CNT_W-1)
//   CNT_W            width of each channel's debounce counter
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst        synchronous, active-high reset
//   pin_in[2:0] raw asynchronous pins (bit0 = channel 1 .. bit2 = channel 3)
//   ack[2:0]   per-channel acknowledge pulse, clears the pending flag
//   i1..i3     debounced level per channel
//   i1sig..i3sig pending-event flag per channel
//   overrun[2:0] sticky per-channel overrun, cleared only by rst
//
// Optional feature (macro IO_RISE_ONLY_EN):
//   When defined, only debounced 0->1 transitions raise an event; 1->0
//   transitions still update the debounced level silently.
// -----------------------------------------------------------------------------
module io_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pin_in,
    input  logic [2:0] ack,
    output logic       i1,
    output logic       i2,
    output logic       i3,
    output logic       i1sig,
    output logic       i2sig,
    output logic       i3sig,
    output logic [2:0] overrun
);

    localparam int NCH = 3;

    // Terminal count: the edge that sees cnt at this value with the mismatch
    // still present is the edge that accepts the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,   // sync2 agrees with the debounced level
        CONFIRM = 1'b1    // sync2 differs, counting persistence
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NCH-1:0]   sync1_q, sync1_d;
    logic [NCH-1:0]   sync2_q, sync2_d;
    logic [NCH-1:0]   deb_q,   deb_d;
    logic [NCH-1:0]   pend_q,  pend_d;
    logic [NCH-1:0]   ovr_q,   ovr_d;
    state_t           state_q [NCH];
    state_t           state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];

    // Per-channel strobes, combinational helpers only
    logic [NCH-1:0]   flip;
    logic [NCH-1:0]   evt;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no path
        // leaves it unassigned; a missed default here would infer a latch.
        sync1_d = pin_in;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        flip    = '0;
        evt     = '0;

        for (int ch = 0; ch < NCH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];

            // ---------------- debounce FSM ----------------
            unique case (state_q[ch])
                STABLE: begin
                    cnt_d[ch] = '0;
                    if (sync2_q[ch] != deb_q[ch]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // One cycle of persistence is already satisfied.
                            flip[ch] = 1'b1;
                        end else begin
                            state_d[ch] = CONFIRM;
                            cnt_d[ch]   = CNT_W'(1);
                        end
                    end
                end

                CONFIRM: begin
                    if (sync2_q[ch] == deb_q[ch]) begin
                        // Glitch rejected: input went back before the count
                        // completed, so no event and the count is discarded.
                        state_d[ch] = STABLE;
                        cnt_d[ch]   = '0;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        flip[ch]    = 1'b1;
                        state_d[ch] = STABLE;
                        cnt_d[ch]   = '0;
                    end else begin
                        cnt_d[ch]   = cnt_q[ch] + CNT_W'(1);
                    end
                end

                default: begin
                    state_d[ch] = STABLE;
                    cnt_d[ch]   = '0;
                end
            endcase

            if (flip[ch]) begin
                deb_d[ch] = ~deb_q[ch];
            end

            // ---------------- event qualification ----------------
`ifdef IO_RISE_ONLY_EN
            // Only a 0->1 acceptance counts; the old level is 0 on a rise.
            evt[ch] = flip[ch] & ~deb_q[ch];
`else
            evt[ch] = flip[ch];
`endif

            // ---------------- pending / overrun ----------------
            // Event has priority over ack. An ack on the same edge consumes
            // the old event, so overrun is recorded only if it is absent.
            if (evt[ch]) begin
                pend_d[ch] = 1'b1;
                if (pend_q[ch] && !ack[ch]) begin
                    ovr_d[ch] = 1'b1;
                end
            end else if (ack[ch]) begin
                pend_d[ch] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge; blocking would let sync2 see this edge's sync1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                state_q[ch] <= STABLE;
                cnt_q[ch]   <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            for (int ch = 0; ch < NCH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: straight from flops, no combinational path from inputs
    // ------------------------------------------------------------------------
    assign i1      = deb_q[0];
    assign i2      = deb_q[1];
    assign i3      = deb_q[2];
    assign i1sig   = pend_q[0];
    assign i2sig   = pend_q[1];
    assign i3sig   = pend_q[2];
    assign overrun = ovr_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_io_input_conditioner
//
// Directed bench for io_input_conditioner built with DEBOUNCE_CYCLES = 4, so
// a pin change held from before edge 0 is accepted at edge 5: after six
// clock edges counted from the edge that first samples the new pin.
// A table of {inputs, cycles, expected outputs} drives most of the run; a
// hand-written per-cycle latency sequence follows. Expectations that depend
// on IO_RISE_ONLY_EN are selected from the RO constant.
// -----------------------------------------------------------------------------
module tb_io_input_conditioner;

    localparam int DEB = 4;

`ifdef IO_RISE_ONLY_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pin_in = 3'b000;
    logic [2:0] ack = 3'b000;
    logic       i1, i2, i3, i1sig, i2sig, i3sig;
    logic [2:0] overrun;

    always #5 clk = ~clk;

    io_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pin_in (pin_in),
        .ack    (ack),
        .i1     (i1),
        .i2     (i2),
        .i3     (i3),
        .i1sig  (i1sig),
        .i2sig  (i2sig),
        .i3sig  (i3sig),
        .overrun(overrun)
    );

    wire [2:0] lvl = {i3, i2, i1};
    wire [2:0] sig = {i3sig, i2sig, i1sig};

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] pin;
        logic [2:0] ack;
        int         n;      // clock edges to apply these inputs for
        logic [2:0] e_lvl;
        logic [2:0] e_sig;
        logic [2:0] e_ovr;
    } vec_t;

    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    // Advance n posedges, leaving time 1 unit past the last one for sampling.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add(input string name, input logic r, input logic [2:0] p,
                       input logic [2:0] a, input int n, input logic [2:0] el,
                       input logic [2:0] es, input logic [2:0] eo);
        vec_t v;
        v.name = name; v.rst = r; v.pin = p; v.ack = a; v.n = n;
        v.e_lvl = el; v.e_sig = es; v.e_ovr = eo;
        vecs.push_back(v);
    endtask

    initial begin
        //   name            rst pin     ack    n  lvl     sig                     ovr
        add("reset",          1, 3'b000, 3'b000, 2, 3'b000, 3'b000,                 3'b000);
        add("all_rise_early", 0, 3'b111, 3'b000, 5, 3'b000, 3'b000,                 3'b000);
        add("all_rise",       0, 3'b111, 3'b000, 1, 3'b111, 3'b111,                 3'b000);
        add("ack_all",        0, 3'b111, 3'b111, 1, 3'b111, 3'b000,                 3'b000);
        add("hold",           0, 3'b111, 3'b000, 3, 3'b111, 3'b000,                 3'b000);
        add("ack_idle",       0, 3'b111, 3'b111, 1, 3'b111, 3'b000,                 3'b000);
        add("reset_mid",      1, 3'b111, 3'b000, 1, 3'b000, 3'b000,                 3'b000);
        add("ch1_early",      0, 3'b001, 3'b000, 5, 3'b000, 3'b000,                 3'b000);
        add("ch1_latency",    0, 3'b001, 3'b000, 1, 3'b001, 3'b001,                 3'b000);
        // ch2 high for 3 cycles: longest pulse that must still be rejected
        add("ch2_glitch_hi",  0, 3'b011, 3'b000, 3, 3'b001, 3'b001,                 3'b000);
        add("ch2_glitch_lo",  0, 3'b001, 3'b000, 6, 3'b001, 3'b001,                 3'b000);
        // ch2 high for 4 cycles: shortest pulse accepted, rise lands at edge 5
        add("ch2_pulse_hi",   0, 3'b011, 3'b000, 4, 3'b001, 3'b001,                 3'b000);
        add("ch2_pulse_rise", 0, 3'b001, 3'b000, 2, 3'b011, 3'b011,                 3'b000);
        add("ack_ch12",       0, 3'b001, 3'b011, 1, 3'b011, 3'b000,                 3'b000);
        add("ch2_fall_wait",  0, 3'b001, 3'b000, 2, 3'b011, 3'b000,                 3'b000);
        add("ch2_fall",       0, 3'b001, 3'b000, 1, 3'b001, RO ? 3'b000 : 3'b010,   3'b000);
        add("ack_ch2",        0, 3'b001, 3'b010, 1, 3'b001, 3'b000,                 3'b000);
        add("ch3_rise",       0, 3'b101, 3'b000, 6, 3'b101, 3'b100,                 3'b000);
        add("ch3_fall_ovr",   0, 3'b001, 3'b000, 6, 3'b001, 3'b100,                 RO ? 3'b000 : 3'b100);
        add("ack_ch3",        0, 3'b001, 3'b100, 1, 3'b001, 3'b000,                 RO ? 3'b000 : 3'b100);
        add("ovr_sticky",     0, 3'b001, 3'b000, 2, 3'b001, 3'b000,                 RO ? 3'b000 : 3'b100);
        add("ch1_fall",       0, 3'b000, 3'b000, 6, 3'b000, RO ? 3'b000 : 3'b001,   RO ? 3'b000 : 3'b100);
        add("ack_ch1",        0, 3'b000, 3'b001, 1, 3'b000, 3'b000,                 RO ? 3'b000 : 3'b100);
        add("ch1_rise",       0, 3'b001, 3'b000, 6, 3'b001, 3'b001,                 RO ? 3'b000 : 3'b100);
        add("ch1_fall_wait",  0, 3'b000, 3'b000, 5, 3'b001, 3'b001,                 RO ? 3'b000 : 3'b100);
        // ack lands on the very edge the new ch1 event fires
        add("ch1_simul",      0, 3'b000, 3'b001, 1, 3'b000, RO ? 3'b000 : 3'b001,   RO ? 3'b000 : 3'b100);
        add("ch1_simul_hold", 0, 3'b000, 3'b000, 1, 3'b000, RO ? 3'b000 : 3'b001,   RO ? 3'b000 : 3'b100);
        add("reset_clr_ovr",  1, 3'b000, 3'b000, 1, 3'b000, 3'b000,                 3'b000);

        foreach (vecs[k]) begin
            rst    = vecs[k].rst;
            pin_in = vecs[k].pin;
            ack    = vecs[k].ack;
            tick(vecs[k].n);
            check({vecs[k].name, ".lvl"}, lvl,     vecs[k].e_lvl);
            check({vecs[k].name, ".sig"}, sig,     vecs[k].e_sig);
            check({vecs[k].name, ".ovr"}, overrun, vecs[k].e_ovr);
        end

        // Per-cycle latency on ch3 from a fresh reset: level and flag must
        // appear exactly after the sixth edge, not one earlier or later.
        rst = 1'b1; pin_in = 3'b000; ack = 3'b000;
        tick(1);
        rst = 1'b0; pin_in = 3'b100;
        for (int t = 1; t <= 8; t++) begin
            tick(1);
            check($sformatf("lat3_lvl_t%0d", t), lvl, (t >= DEB + 2) ? 3'b100 : 3'b000);
            check($sformatf("lat3_sig_t%0d", t), sig, (t >= DEB + 2) ? 3'b100 : 3'b000);
        end

        // Reset asserted mid-debounce discards the partial count: after the
        // reset the full six edges are needed again.
        pin_in = 3'b110;
        tick(3);
        rst = 1'b1;
        tick(1);
        check("rst_mid_deb", lvl, 3'b000);
        rst = 1'b0;
        tick(DEB + 1);
        check("rst_mid_deb_early", lvl, 3'b000);
        tick(1);
        check("rst_mid_deb_done", lvl, 3'b110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
